// File: rtl/video_write_scheduler.sv
// video_write_scheduler: defers CPU video writes into a FIFO and drains a snapshot of it
// on frame_end (or immediately in pass-through mode), preserving write order.
module video_write_scheduler #(
  parameter int DEPTH_LOG2 = 4,
  parameter int AW = 21,
  parameter int DW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cs,
  input  logic                  write,
  input  logic [AW-1:0]         addr,
  input  logic [DW-1:0]         wr_data,
  input  logic                  defer_en,
  input  logic                  frame_end,
  input  logic                  clr_ovf,
  output logic                  video_cs,
  output logic                  video_wr,
  output logic [AW-1:0]         video_addr,
  output logic [DW-1:0]         video_wr_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  busy,
  output logic                  ovf
);
  localparam int DEPTH = 2 ** DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(DEPTH);
  typedef enum logic {IDLE, DRAIN} state_t;
  state_t state;
  logic [AW+DW-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0] drain_cnt;
  logic req, pass, pop, push, drop, start;
  always_comb begin
    req   = cs & write;
    pass  = req & ~defer_en & (state == IDLE) & (count == '0);
    pop   = state == DRAIN;
    push  = req & ~pass & ((count != FULL) | pop);
    drop  = req & ~pass & (count == FULL) & ~pop;
    start = (state == IDLE) & (count != '0) & (frame_end | ~defer_en);
  end
  assign busy = state == DRAIN;
  always_ff @(posedge clk)
    if (push && !reset) mem[wr_ptr] <= {addr, wr_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      drain_cnt     <= '0;
      ovf           <= 1'b0;
      video_cs      <= 1'b0;
      video_wr      <= 1'b0;
      video_addr    <= '0;
      video_wr_data <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count    <= count + (DEPTH_LOG2 + 1)'(push) - (DEPTH_LOG2 + 1)'(pop);
      video_cs <= pass | pop;
      video_wr <= pass | pop;
      if (pass) {video_addr, video_wr_data} <= {addr, wr_data};
      else if (pop) {video_addr, video_wr_data} <= mem[rd_ptr];
      ovf <= drop | (ovf & ~clr_ovf);
      // the snapshot bounds this drain; later pushes wait for the next one
      if (start) begin
        state     <= DRAIN;
        drain_cnt <= count;
      end else if (pop) begin
        drain_cnt <= drain_cnt - 1'b1;
        if (drain_cnt == 1) state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_video_write_scheduler.sv
// tb_video_write_scheduler: queue-based reference model feeding a scoreboard that checks
// every cycle's video writes, count, busy and ovf.
module tb_video_write_scheduler;
  logic clk = 0, reset = 1, cs = 0, write = 0, defer_en = 0, frame_end = 0, clr_ovf = 0;
  logic [20:0] addr = 0;
  logic [31:0] wr_data = 0;
  logic video_cs, video_wr, busy, ovf;
  logic [20:0] video_addr;
  logic [31:0] video_wr_data;
  logic [4:0] count;
  int checks = 0, failures = 0;
  logic [52:0] q[$], exp_q[$];
  int rem = 0;
  bit busy_m = 0, ovf_m = 0;

  video_write_scheduler dut (
    .clk(clk), .reset(reset), .cs(cs), .write(write), .addr(addr), .wr_data(wr_data),
    .defer_en(defer_en), .frame_end(frame_end), .clr_ovf(clr_ovf),
    .video_cs(video_cs), .video_wr(video_wr), .video_addr(video_addr),
    .video_wr_data(video_wr_data), .count(count), .busy(busy), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // reference model: pending writes in a queue, a drain is a count of remaining pops
  always @(posedge clk) begin : model
    int size0;
    bit req, pass, was_busy, dropped;
    if (reset) begin
      q.delete(); exp_q.delete(); rem = 0; busy_m = 0; ovf_m = 0;
    end else begin
      size0 = q.size();
      was_busy = busy_m;
      req = cs & write;
      pass = req && !defer_en && !busy_m && size0 == 0;
      dropped = 0;
      if (busy_m) begin
        exp_q.push_back(q.pop_front());
        rem--;
        if (rem == 0) busy_m = 0;
      end
      if (pass) exp_q.push_back({addr, wr_data});
      else if (req) begin
        if (q.size() < 16) q.push_back({addr, wr_data});
        else dropped = 1;
      end
      if (dropped) ovf_m = 1;
      else if (clr_ovf) ovf_m = 0;
      if (!was_busy && size0 > 0 && (frame_end || !defer_en)) begin
        busy_m = 1;
        rem = size0;
      end
    end
  end

  always @(posedge clk) begin : monitor
    logic [52:0] e;
    #1;
    chk("video_cs", video_cs, exp_q.size() > 0);
    chk("video_wr", video_wr, exp_q.size() > 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (video_cs) begin
        chk("video_addr", video_addr, e[52:32]);
        chk("video_wr_data", video_wr_data, e[31:0]);
      end
    end
    chk("count", count, q.size());
    chk("busy", busy, busy_m);
    chk("ovf", ovf, ovf_m);
  end

  task automatic drive(input bit c, input bit w, input logic [20:0] a, input logic [31:0] d,
                       input bit fe, input bit clr);
    cs = c; write = w; addr = a; wr_data = d; frame_end = fe; clr_ovf = clr;
    @(negedge clk);
    cs = 0; write = 0; frame_end = 0; clr_ovf = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [20:0] a, input logic [31:0] d);
    drive(1, 1, a, d, 0, 0);
  endtask

  initial begin
    @(negedge clk);
    drive(1, 1, 21'h55, 32'hdead, 0, 0);
    reset = 0;
    chk("reset_video_addr", video_addr, 0);
    chk("reset_video_wr_data", video_wr_data, 0);
    defer_en = 0;
    idle(2);
    wr(21'h0C004, 32'h123);
    idle(3);
    drive(1, 0, 21'h1, 32'h1, 0, 0);
    defer_en = 1;
    for (int i = 0; i < 3; i++) wr(21'h100 + 21'(i), 32'hA0 + i);
    idle(2);
    drive(0, 0, 0, 0, 1, 0);
    idle(6);
    for (int i = 0; i < 2; i++) wr(21'h200 + 21'(i), 32'hB0 + i);
    drive(0, 0, 0, 0, 1, 0);
    wr(21'h2DD, 32'hD);
    drive(0, 0, 0, 0, 1, 0);
    idle(5);
    drive(0, 0, 0, 0, 1, 0);
    idle(4);
    for (int i = 0; i < 17; i++) wr(21'h300 + 21'(i), 32'hC00 + i);
    idle(2);
    drive(1, 1, 21'h3FF, 32'hFFF, 0, 1);
    idle(1);
    drive(0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0);
    idle(20);
    for (int i = 0; i < 8; i++) wr(21'h400 + 21'(i), 32'hE00 + i);
    drive(0, 0, 0, 0, 1, 0);
    idle(2);
    reset = 1;
    @(negedge clk);
    reset = 0;
    drive(0, 0, 0, 0, 1, 0);
    idle(4);
    wr(21'h5AA, 32'h58);
    defer_en = 0;
    wr(21'h5BB, 32'h59);
    idle(6);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) == 0) defer_en = ~defer_en;
      reset = $urandom_range(0, 499) == 0;
      drive($urandom_range(0, 1), $urandom_range(0, 2) != 0, 21'($urandom), $urandom,
            $urandom_range(0, 29) == 0, $urandom_range(0, 39) == 0);
    end
    reset = 0;
    defer_en = 0;
    idle(40);
    chk("final_count", count, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
